// File: rtl/pulse_burst_gen_pkg.sv
// Shared definitions for the pulse burst generator.
//   state_e       : FSM state encoding (IDLE=0, HIGH=1, LOW=2), also used by
//                   the pulse counter family.
//   param_fits()  : helper for the elaboration-time parameter check. It tests
//                   whether a count needs no more than a given number of bits.
package pulse_burst_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Returns 1 when value fits in an unsigned field of width bits.
    function automatic bit param_fits(input longint value, input int width);
        return (value >= 0) && ((width >= 63) || ((value >> width) == 0));
    endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter that times one HIGH or LOW phase of a burst.
// Ports:
//   clk       in   system clock
//   rstn      in   synchronous active-low reset; clears the count
//   load      in   loads load_val. load takes priority over dec.
//   load_val  in   CNT_BIT_WID-bit reload value
//   dec       in   decrements the count by one. The count stops at zero.
//   zero      out  high when the count is zero
module pulse_phase_timer #(
    parameter int CNT_BIT_WID = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   load,
    input  logic [CNT_BIT_WID-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [CNT_BIT_WID-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together at the edge; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse burst generator. Each accepted trigger produces PULSE_NUM pulses.
// Each pulse stays high for HIGH_CYC cycles and then low for LOW_CYC cycles.
// Ports:
//   clk            in   system clock
//   rstn           in   synchronous active-low reset
//   en             in   block enable. When low, bursts are blocked, and a
//                       running burst is aborted.
//   trig           in   single-cycle trigger pulse
//   p_out          out  registered burst waveform
//   busy           out  high while a burst is running
//   burst_done     out  one-cycle pulse when a burst completes normally
//   burst_abort    out  one-cycle pulse when en drops during a burst
//   pulse_idx      out  index of the current pulse; 0 while idle
//   trig_miss_cnt  out  saturating count of triggers dropped while busy
module pulse_burst_gen
    import pulse_burst_gen_pkg::*;
#(
    parameter int CNT_BIT_WID = 32,
    parameter int HIGH_CYC    = 10,
    parameter int LOW_CYC     = 10,
    parameter int PULSE_NUM   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   trig,
    output logic                   p_out,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   burst_abort,
    output logic [CNT_BIT_WID-1:0] pulse_idx,
    output logic [CNT_BIT_WID-1:0] trig_miss_cnt
);

    // Reject unusable parameter sets at elaboration time.
    generate
        if (CNT_BIT_WID < 1 || HIGH_CYC < 1 || LOW_CYC < 1 || PULSE_NUM < 1) begin : g_bad_range
            $error("pulse_burst_gen: CNT_BIT_WID, HIGH_CYC, LOW_CYC and PULSE_NUM must all be >= 1");
        end
        if (!param_fits(longint'(HIGH_CYC) - 1, CNT_BIT_WID) ||
            !param_fits(longint'(LOW_CYC) - 1, CNT_BIT_WID) ||
            !param_fits(longint'(PULSE_NUM) - 1, CNT_BIT_WID)) begin : g_bad_width
            $error("pulse_burst_gen: phase lengths or pulse count do not fit in CNT_BIT_WID bits");
        end
    endgenerate

    // The timer runs from N-1 down to 0, so each phase lasts exactly N cycles.
    localparam logic [CNT_BIT_WID-1:0] HIGH_LOAD = CNT_BIT_WID'(HIGH_CYC - 1);
    localparam logic [CNT_BIT_WID-1:0] LOW_LOAD  = CNT_BIT_WID'(LOW_CYC - 1);
    localparam logic [CNT_BIT_WID-1:0] LAST_IDX  = CNT_BIT_WID'(PULSE_NUM - 1);

    state_e                 state;
    logic                   tmr_load;
    logic [CNT_BIT_WID-1:0] tmr_load_val;
    logic                   tmr_dec;
    logic                   tmr_zero;
    logic                   last_pulse;

    assign last_pulse = (pulse_idx == LAST_IDX);

    pulse_phase_timer #(
        .CNT_BIT_WID (CNT_BIT_WID)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Timer control. This logic follows the same transitions as the FSM
    // below. An abort or the end of a burst loads zero, so the timer is
    // already cleared when the FSM returns to IDLE.
    always_comb begin
        // NOTE: every signal gets a default before the case; without it a
        // path that leaves a signal unassigned infers a latch.
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en && trig) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (!en) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LOW_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_LOW: begin
                if (!en) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = last_pulse ? '0 : HIGH_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    // FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            p_out         <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            burst_abort   <= 1'b0;
            pulse_idx     <= '0;
            trig_miss_cnt <= '0;
        end else begin
            burst_done  <= 1'b0;
            burst_abort <= 1'b0;

            // A trigger during a burst is dropped and counted as a miss.
            // Abort takes priority, so a trigger in the abort cycle is not
            // counted.
            if ((state != ST_IDLE) && en && trig && !(&trig_miss_cnt)) begin
                trig_miss_cnt <= trig_miss_cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (en && trig) begin
                        state     <= ST_HIGH;
                        p_out     <= 1'b1;
                        busy      <= 1'b1;
                        pulse_idx <= '0;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (!en) begin
                        state       <= ST_IDLE;
                        p_out       <= 1'b0;
                        busy        <= 1'b0;
                        burst_abort <= 1'b1;
                        pulse_idx   <= '0;
                    end else if (tmr_zero) begin
                        if (state == ST_HIGH) begin
                            state <= ST_LOW;
                            p_out <= 1'b0;
                        end else if (last_pulse) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            burst_done <= 1'b1;
                            pulse_idx  <= '0;
                        end else begin
                            state     <= ST_HIGH;
                            p_out     <= 1'b1;
                            pulse_idx <= pulse_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    p_out     <= 1'b0;
                    busy      <= 1'b0;
                    pulse_idx <= '0;
                end
            endcase
        end
    end

endmodule
